stall_buffer_ctrl: RTL and testbench
====================================

// Module: stall_buffer_ctrl
// PURPOSE
//  Valid/ready controller and storage sequencer for a 2-slot pipeline stall buffer
//  (slot 0 = regular, slot 1 = stall). Sits between two pipeline stages.
//  Converts the upstream handshake into enq/deq/flush actions on the slots.
//  Also produces the stage stall signal and stall/flush performance counters.
// PARAMETERS
//  DATA_W  32  width of the pipeline payload (instruction/result word)
//  CNT_W   16  width of the saturating performance counters
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  flush         in   1       pipeline flush (e.g. branch redirect); highest priority
//  up_valid      in   1       upstream stage presents up_data
//  up_data       in   DATA_W  upstream payload
//  up_ready      out  1       buffer accepts this cycle; !up_ready = upstream stall
//  dn_valid      out  1       slot 0 holds a valid entry
//  dn_data       out  DATA_W  slot 0 contents
//  dn_ready      in   1       downstream stage consumes dn_data this cycle
//  occupancy     out  2       entries held: 0, 1 or 2
//  stall_cycles  out  CNT_W   cycles with up_valid && !up_ready; saturating
//  flushed_cnt   out  CNT_W   entries discarded by flush; saturating
// BEHAVIOUR
//  - State: EMPTY (0 entries), ONE (slot 0 valid), FULL (slots 0 and 1 valid).
//  - up_ready = (state != FULL). dn_valid = (state != EMPTY). dn_data = slot0.
//    All three outputs are decoded from registered state only; no comb path in->out.
//  - acc = up_valid && up_ready; pop = dn_valid && dn_ready. Both evaluated same cycle.
//  - Transitions when flush = 0:
//    EMPTY: acc -> ONE, slot0 <= up_data.
//    ONE:   acc & pop -> ONE, slot0 <= up_data | acc only -> FULL, slot1 <= up_data
//           | pop only -> EMPTY, slot0 <= 0.
//    FULL:  pop -> ONE, slot0 <= slot1, slot1 <= 0 (up_ready = 0, so acc is impossible).
//    Any other case: hold state and slots.
//  - Latency: an entry accepted at edge N is presented on dn_data after edge N.
//    Sustained throughput is 1 entry/cycle while dn_ready stays high.
//  - Order: strict FIFO. Slot 1 only ever shifts into slot 0; it never bypasses slot 0.
//  - Invalid slots read as 0. occupancy counts down on pop. It never wraps below 0 or above 2.
//  - flush: at the next edge, state <= EMPTY and slot0/slot1 <= 0.
//    acc and pop in a flush cycle are discarded; pop does not count as consumed.
//    flushed_cnt += occupancy (saturating). up_ready/dn_valid still reflect the pre-flush state that cycle.
//  - Counters: stall_cycles += 1 each cycle up_valid && !up_ready, including flush cycles.
//    Both counters saturate at all-ones. They are cleared by reset only, not by flush.
//  - reset (sync): state EMPTY, slots 0, up_ready=1, dn_valid=0, dn_data=0,
//    occupancy=0, stall_cycles=0, flushed_cnt=0.
//    reset beats flush; a reset mid-transfer drops all entries with no counter update.
//  - Illegal state encoding decodes to EMPTY at the next edge.
// STRUCTURE
//  - Shared package: 2-bit state encoding (ST_EMPTY=0, ST_ONE=1, ST_FULL=2).
//    It also holds the SLOT_REGULAR=0 / SLOT_STALL=1 indices, reused by the other stall-pipeline stages.
//  - One sub-module, stall_slot_pair: 2 x DATA_W registers with load0/load1/shift/clear controls.
//    This module holds the FSM, handshake decode and counters.
// TESTING
//  T1 reset: assert reset 2 cycles -> up_ready=1, dn_valid=0, dn_data=0, occupancy=0, both counters 0.
//  T2 streaming: dn_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> dn_data 0x11,0x22,0x33
//     on consecutive cycles, occupancy stays 1, stall_cycles=0.
//  T3 stall fill: dn_ready=0, push 0xA0,0xA1,0xA2 -> 0xA0,0xA1 accepted, up_ready=0 on 3rd cycle.
//     Hold 4 cycles -> stall_cycles=4. Release dn_ready -> outputs 0xA0, 0xA1, 0xA2 in order.
//  T4 simultaneous: in ONE with slot0=0x5, up_valid (0x6) and dn_ready together -> next dn_data=0x6, occupancy=1.
//  T5 flush: FULL (0xB0,0xB1), flush with up_valid=1 and dn_ready=1 -> next cycle occupancy=0,
//     dn_valid=0, flushed_cnt=2, 0xB0 never reported as consumed, upstream word dropped.
//  T6 saturation: CNT_W=4, hold FULL with up_valid=1 for 20 cycles -> stall_cycles=15 and stays 15.
//     Then reset mid-FULL -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/stall_buffer_ctrl_pkg.sv
// ============================================================================
// Module      : stall_buffer_ctrl_pkg
// Description : Shared state encoding and slot indices for the stall pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stall_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic SLOT_REGULAR = 1'b0;
  localparam logic SLOT_STALL   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/stall_buffer_ctrl_slot_pair.sv
// ============================================================================
// Module      : stall_slot_pair
// Description : Two payload registers (regular + stall) with load/shift/clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_slot_pair
  import stall_buffer_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load0,
  input  logic              load1,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] slot0
);

  logic [DATA_W-1:0] r_slot [2];

  // Shift moves the stall slot forward and zeroes it; a vacated slot reads as 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_slot[SLOT_REGULAR] <= '0;
      r_slot[SLOT_STALL]   <= '0;
    end else begin
      if (shift) begin
        r_slot[SLOT_REGULAR] <= r_slot[SLOT_STALL];
        r_slot[SLOT_STALL]   <= '0;
      end
      if (load0) r_slot[SLOT_REGULAR] <= din;
      if (load1) r_slot[SLOT_STALL]   <= din;
    end
  end

  assign slot0 = r_slot[SLOT_REGULAR];

endmodule

`default_nettype wire

// File: rtl/stall_buffer_ctrl.sv
// ============================================================================
// Module      : stall_buffer_ctrl
// Description : Valid/ready controller for a 2-slot stall buffer with counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_buffer_ctrl
  import stall_buffer_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flushed_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_acc;
  logic              w_pop;
  logic              w_load0;
  logic              w_load1;
  logic              w_shift;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flushed_cnt;
  logic [CNT_W:0]    w_flush_sum;

  assign up_ready = (r_state != ST_FULL);
  assign dn_valid = (r_state != ST_EMPTY);
  assign w_acc    = up_valid && up_ready;
  assign w_pop    = dn_valid && dn_ready;

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load0     = 1'b0;
    w_load1     = 1'b0;
    w_shift     = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_load0     = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_load0 = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = ST_FULL;
            w_load1     = 1'b1;
          end else if (w_pop) begin
            // Stall slot is already zero in ONE, so a shift empties slot 0.
            w_state_nxt = ST_EMPTY;
            w_shift     = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_shift     = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end else begin
      w_state_nxt = ST_EMPTY;
    end
  end

  stall_slot_pair #(
    .DATA_W (DATA_W)
  ) u_slots (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load0 (w_load0),
    .load1 (w_load1),
    .shift (w_shift),
    .din   (up_data),
    .slot0 (dn_data)
  );

  assign w_flush_sum = {1'b0, r_flushed_cnt} + {{(CNT_W-1){1'b0}}, occupancy};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flushed_cnt  <= '0;
    end else begin
      if (up_valid && !up_ready && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush)
        r_flushed_cnt <= w_flush_sum[CNT_W] ? '1 : w_flush_sum[CNT_W-1:0];
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flushed_cnt  = r_flushed_cnt;

endmodule

`default_nettype wire

// File: tb/tb_stall_buffer_ctrl.sv
// ============================================================================
// Module      : tb_stall_buffer_ctrl
// Description : Directed self-checking bench for stall_buffer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_buffer_ctrl;

  localparam int c_data_w = 32;
  localparam int c_cnt_w  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                up_valid;
  logic [c_data_w-1:0] up_data;
  logic                up_ready;
  logic                dn_valid;
  logic [c_data_w-1:0] dn_data;
  logic                dn_ready;
  logic [1:0]          occupancy;
  logic [c_cnt_w-1:0]  stall_cycles;
  logic [c_cnt_w-1:0]  flushed_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  stall_buffer_ctrl #(
    .DATA_W (c_data_w),
    .CNT_W  (c_cnt_w)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .up_valid     (up_valid),
    .up_data      (up_data),
    .up_ready     (up_ready),
    .dn_valid     (dn_valid),
    .dn_data      (dn_data),
    .dn_ready     (dn_ready),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .flushed_cnt  (flushed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are then changed and outputs sampled 1ns later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".up_ready"}, {31'd0, up_ready}, 32'd1);
    chk({tag, ".dn_valid"}, {31'd0, dn_valid}, 32'd0);
    chk({tag, ".dn_data"},  dn_data, 32'd0);
    chk({tag, ".occ"},      {30'd0, occupancy}, 32'd0);
    chk({tag, ".stall"},    {28'd0, stall_cycles}, 32'd0);
    chk({tag, ".flushed"},  {28'd0, flushed_cnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;

    // T1 reset
    step(2);
    chk_reset_vals("t1");
    reset = 1'b0;

    // T2 streaming
    dn_ready = 1'b1; up_valid = 1'b1; up_data = 32'h11;
    step();
    chk("t2.d11", dn_data, 32'h11);
    chk("t2.occ1", {30'd0, occupancy}, 32'd1);
    up_data = 32'h22; step();
    chk("t2.d22", dn_data, 32'h22);
    chk("t2.occ2", {30'd0, occupancy}, 32'd1);
    up_data = 32'h33; step();
    chk("t2.d33", dn_data, 32'h33);
    up_valid = 1'b0; step();
    chk("t2.empty_valid", {31'd0, dn_valid}, 32'd0);
    chk("t2.empty_data", dn_data, 32'd0);
    chk("t2.stall", {28'd0, stall_cycles}, 32'd0);

    // T3 stall fill
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hA0; step();
    chk("t3.ready_one", {31'd0, up_ready}, 32'd1);
    up_data = 32'hA1; step();
    chk("t3.occ_full", {30'd0, occupancy}, 32'd2);
    chk("t3.ready_full", {31'd0, up_ready}, 32'd0);
    up_data = 32'hA2; step(4);
    chk("t3.stall4", {28'd0, stall_cycles}, 32'd4);
    chk("t3.dA0", dn_data, 32'hA0);
    dn_ready = 1'b1; step();
    chk("t3.dA1", dn_data, 32'hA1);
    chk("t3.occ_after_pop", {30'd0, occupancy}, 32'd1);
    step();
    chk("t3.dA2", dn_data, 32'hA2);
    up_valid = 1'b0; step();
    chk("t3.drained", {31'd0, dn_valid}, 32'd0);
    chk("t3.stall5", {28'd0, stall_cycles}, 32'd5);

    // T4 simultaneous accept and pop
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h5; step();
    chk("t4.d5", dn_data, 32'h5);
    up_data = 32'h6; dn_ready = 1'b1; step();
    chk("t4.d6", dn_data, 32'h6);
    chk("t4.occ", {30'd0, occupancy}, 32'd1);
    up_valid = 1'b0; step();

    // T5 flush from FULL with handshakes active
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hB0; step();
    up_data = 32'hB1; step();
    chk("t5.occ_full", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; up_data = 32'hB2; dn_ready = 1'b1;
    #1;
    chk("t5.pre_ready", {31'd0, up_ready}, 32'd0);
    chk("t5.pre_valid", {31'd0, dn_valid}, 32'd1);
    step();
    flush = 1'b0; up_valid = 1'b0;
    chk("t5.occ0", {30'd0, occupancy}, 32'd0);
    chk("t5.valid0", {31'd0, dn_valid}, 32'd0);
    chk("t5.data0", dn_data, 32'd0);
    chk("t5.flushed2", {28'd0, flushed_cnt}, 32'd2);
    chk("t5.stall6", {28'd0, stall_cycles}, 32'd6);
    step();
    chk("t5.dropped", {31'd0, dn_valid}, 32'd0);
    // flush from ONE adds 1; flush while EMPTY adds nothing
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hC0; step();
    up_valid = 1'b0; flush = 1'b1; step();
    chk("t5.flushed3", {28'd0, flushed_cnt}, 32'd3);
    step();
    flush = 1'b0;
    chk("t5.flush_empty", {28'd0, flushed_cnt}, 32'd3);

    // T6 counter saturation, then reset mid-FULL
    up_valid = 1'b1; up_data = 32'hD0; step();
    up_data = 32'hD1; step();
    step(20);
    chk("t6.sat", {28'd0, stall_cycles}, 32'd15);
    step(2);
    chk("t6.sat_hold", {28'd0, stall_cycles}, 32'd15);
    chk("t6.dD0", dn_data, 32'hD0);
    reset = 1'b1; step();
    chk_reset_vals("t6.rst");
    reset = 1'b0; up_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
